// File: rtl/aukv_eggs_soc_top.sv
// rtl/aukv_eggs_soc_top.sv - UART status reporter and LED command engine
//
// Purpose: 8N1 UART transceiver on one clock. A free-running timer asks for a
// status byte {3'b101, switches} to be sent periodically; bytes received
// with a valid stop bit and a 3'b101 prefix drive the LEDs.
//
// Ports:
//   i_clk     in   1  system clock, rising edge
//   i_rstn    in   1  asynchronous active-low reset
//   i_rx      in   1  UART receive line, idle high, asynchronous
//   o_tx      out  1  UART transmit line, idle high
//   o_led     out  3  LED outputs
//   i_switch  in   5  slide switches, asynchronous
module aukv_eggs_soc_top #(
  parameter int CLK_HZ        = 50_000_000,
  parameter int BAUD          = 115_200,
  parameter int REPORT_PERIOD = 50_000
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic       i_rx,
  output logic       o_tx,
  output logic [2:0] o_led,
  input  logic [4:0] i_switch
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int TMR_W        = $clog2(REPORT_PERIOD);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(REPORT_PERIOD - 1);
  localparam logic [TMR_W-1:0] TMR_ONE   = TMR_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } uart_state_e;

  // Synchronizers
  logic       rx_meta_q, rx_meta_d;
  logic       rx_sync_q, rx_sync_d;
  logic       rx_prev_q, rx_prev_d;
  logic [4:0] sw_meta_q, sw_meta_d;
  logic [4:0] sw_sync_q, sw_sync_d;

  // Report timer and pending request
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             pending_q, pending_d;
  logic             tmr_expire;

  // Status byte stream into the transmitter
  logic       status_tvalid;
  logic       status_tready;
  logic [7:0] status_tdata;

  // Transmitter
  uart_state_e      tx_state_q, tx_state_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]       tx_bit_q, tx_bit_d;
  logic [7:0]       tx_shift_q, tx_shift_d;
  logic             tx_line_q, tx_line_d;

  // Receiver
  uart_state_e      rx_state_q, rx_state_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]       rx_bit_q, rx_bit_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic             rx_fall;

  // Decoded command stream (only matching, well-framed bytes)
  logic       cmd_tvalid_q, cmd_tvalid_d;
  logic [2:0] cmd_tdata_q, cmd_tdata_d;
  logic [2:0] led_q, led_d;

  always_comb begin
    rx_meta_d = i_rx;
    rx_sync_d = rx_meta_q;
    rx_prev_d = rx_sync_q;
    sw_meta_d = i_switch;
    sw_sync_d = sw_meta_q;
  end

  assign rx_fall = rx_prev_q & ~rx_sync_q;

  // Timer: expiries while a request is still pending merge into it.
  assign tmr_expire    = (timer_q == TMR_LAST);
  assign status_tvalid = pending_q | tmr_expire;
  assign status_tready = (tx_state_q == ST_IDLE);
  assign status_tdata  = {3'b101, sw_sync_q};

  always_comb begin
    timer_d   = tmr_expire ? '0 : timer_q + TMR_ONE;
    pending_d = status_tvalid & ~status_tready;
  end

  // Transmitter FSM
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_line_d  = 1'b1;
    case (tx_state_q)
      ST_IDLE: begin
        if (status_tvalid) begin
          tx_state_d = ST_START;
          tx_cnt_d   = '0;
          tx_shift_d = status_tdata;
        end
      end
      ST_START: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_state_d = ST_DATA;
          tx_cnt_d   = '0;
          tx_bit_d   = 3'd0;
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_ONE;
        end
      end
      ST_DATA: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_shift_d = {1'b1, tx_shift_q[7:1]};
          if (tx_bit_q == 3'd7) begin
            tx_state_d = ST_STOP;
          end else begin
            tx_bit_d = tx_bit_q + 3'd1;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_ONE;
        end
      end
      ST_STOP: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_state_d = ST_IDLE;
          tx_cnt_d   = '0;
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_ONE;
        end
      end
      default: tx_state_d = ST_IDLE;
    endcase
    // Line level follows the next state so o_tx comes straight from a flop.
    case (tx_state_d)
      ST_START: tx_line_d = 1'b0;
      ST_DATA:  tx_line_d = tx_shift_d[0];
      default:  tx_line_d = 1'b1;
    endcase
  end

  // Receiver FSM. Edge detection on the synced line means a held-low
  // break cannot retrigger until the line has gone high again.
  always_comb begin
    rx_state_d   = rx_state_q;
    rx_cnt_d     = rx_cnt_q;
    rx_bit_d     = rx_bit_q;
    rx_shift_d   = rx_shift_q;
    cmd_tvalid_d = 1'b0;
    cmd_tdata_d  = cmd_tdata_q;
    case (rx_state_q)
      ST_IDLE: begin
        if (rx_fall) begin
          rx_state_d = ST_START;
          rx_cnt_d   = '0;
        end
      end
      ST_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d = '0;
          rx_bit_d = 3'd0;
          rx_state_d = rx_sync_q ? ST_IDLE : ST_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_ONE;
        end
      end
      ST_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) begin
            rx_state_d = ST_STOP;
          end else begin
            rx_bit_d = rx_bit_q + 3'd1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_ONE;
        end
      end
      ST_STOP: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_state_d = ST_IDLE;
          rx_cnt_d   = '0;
          if (rx_sync_q && (rx_shift_q[7:5] == 3'b101)) begin
            cmd_tvalid_d = 1'b1;
            cmd_tdata_d  = rx_shift_q[2:0];
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_ONE;
        end
      end
      default: rx_state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    led_d = led_q;
    if (cmd_tvalid_q) begin
      led_d = cmd_tdata_q;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      rx_meta_q    <= 1'b1;
      rx_sync_q    <= 1'b1;
      rx_prev_q    <= 1'b1;
      sw_meta_q    <= '0;
      sw_sync_q    <= '0;
      timer_q      <= '0;
      pending_q    <= 1'b0;
      tx_state_q   <= ST_IDLE;
      tx_cnt_q     <= '0;
      tx_bit_q     <= 3'd0;
      tx_shift_q   <= '0;
      tx_line_q    <= 1'b1;
      rx_state_q   <= ST_IDLE;
      rx_cnt_q     <= '0;
      rx_bit_q     <= 3'd0;
      rx_shift_q   <= '0;
      cmd_tvalid_q <= 1'b0;
      cmd_tdata_q  <= '0;
      led_q        <= '0;
    end else begin
      rx_meta_q    <= rx_meta_d;
      rx_sync_q    <= rx_sync_d;
      rx_prev_q    <= rx_prev_d;
      sw_meta_q    <= sw_meta_d;
      sw_sync_q    <= sw_sync_d;
      timer_q      <= timer_d;
      pending_q    <= pending_d;
      tx_state_q   <= tx_state_d;
      tx_cnt_q     <= tx_cnt_d;
      tx_bit_q     <= tx_bit_d;
      tx_shift_q   <= tx_shift_d;
      tx_line_q    <= tx_line_d;
      rx_state_q   <= rx_state_d;
      rx_cnt_q     <= rx_cnt_d;
      rx_bit_q     <= rx_bit_d;
      rx_shift_q   <= rx_shift_d;
      cmd_tvalid_q <= cmd_tvalid_d;
      cmd_tdata_q  <= cmd_tdata_d;
      led_q        <= led_d;
    end
  end

  assign o_tx  = tx_line_q;
  assign o_led = led_q;

endmodule

// File: tb/tb_aukv_eggs_soc_top.sv
// tb/tb_aukv_eggs_soc_top.sv - directed bench for the UART status/LED shell
module tb_aukv_eggs_soc_top;

  localparam int CPB = 16;
  localparam int RP  = 400;

  logic       clk = 1'b0;
  logic       rstn;
  logic       rx_drv;
  logic       loop_en;
  logic [4:0] sw;
  logic       tx_w;
  logic       rx_w;
  logic [2:0] led;
  int         cyc;
  int         vectors = 0;
  int         miscompares = 0;

  assign rx_w = loop_en ? tx_w : rx_drv;

  aukv_eggs_soc_top #(
    .CLK_HZ(1_600_000),
    .BAUD(100_000),
    .REPORT_PERIOD(RP)
  ) dut (
    .i_clk(clk),
    .i_rstn(rstn),
    .i_rx(rx_w),
    .o_tx(tx_w),
    .o_led(led),
    .i_switch(sw)
  );

  always #10 clk = ~clk;

  // Clock edges since reset release; status frames start on multiples of RP.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_frame_start(input string tag);
    bit found;
    found = 1'b0;
    for (int i = 0; i < RP + 2 && !found; i++) begin
      @(negedge clk);
      if (cyc % RP == RP - 1) check({tag, "_idle_before"}, tx_w, 1);
      if (cyc != 0 && cyc % RP == 0) found = 1'b1;
    end
    check({tag, "_found"}, found, 1);
    check({tag, "_start_edge"}, tx_w, 0);
  endtask

  // Called at the negedge right after the start edge.
  task automatic check_frame(input logic [7:0] exp, input string tag);
    logic [7:0] got;
    logic       stop_b;
    repeat (CPB / 2) @(negedge clk);
    check({tag, "_start_mid"}, tx_w, 0);
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(negedge clk);
      got[i] = tx_w;
    end
    repeat (CPB) @(negedge clk);
    stop_b = tx_w;
    check({tag, "_data"}, got, exp);
    check({tag, "_stop"}, stop_b, 1);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop_b);
    logic [9:0] frame;
    frame = {stop_b, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_drv = frame[i];
      repeat (CPB) @(negedge clk);
    end
  endtask

  initial begin
    rstn    = 1'b0;
    rx_drv  = 1'b0;
    loop_en = 1'b0;
    sw      = 5'h05;

    // Reset with rx held low
    repeat (25) @(negedge clk);
    check("rst_tx", tx_w, 1);
    check("rst_led", led, 3'b000);
    rstn = 1'b1;
    repeat (200) @(negedge clk);
    check("break_led", led, 3'b000);
    check("break_tx_idle", tx_w, 1);

    // Loopback: first status frame at RP clocks, carries 0xA5
    loop_en = 1'b1;
    wait_frame_start("first");
    check_frame(8'hA5, "first");
    repeat (20) @(negedge clk);
    check("loop_led", led, 3'b101);

    // Directed RX bytes
    loop_en = 1'b0;
    rx_drv  = 1'b1;
    repeat (4) @(negedge clk);
    send_rx(8'hBE, 1'b1);
    repeat (8) @(negedge clk);
    check("match_be", led, 3'b110);
    send_rx(8'h47, 1'b1);
    repeat (8) @(negedge clk);
    check("nomatch_47", led, 3'b110);

    // Framing error, then a quarter-bit glitch, then a good frame
    send_rx(8'hA3, 1'b0);
    rx_drv = 1'b1;
    repeat (24) @(negedge clk);
    check("framing_err", led, 3'b110);
    rx_drv = 1'b0;
    repeat (CPB / 4) @(negedge clk);
    rx_drv = 1'b1;
    repeat (20) @(negedge clk);
    check("glitch_led", led, 3'b110);
    send_rx(8'hA1, 1'b1);
    repeat (8) @(negedge clk);
    check("after_glitch_a1", led, 3'b001);

    // Switch change mid-frame keeps the snapshot
    wait_frame_start("snap");
    sw = 5'h1F;
    check_frame(8'hA5, "snap_old");
    wait_frame_start("snap_next");
    check_frame(8'hBF, "snap_new");

    // Reset during a frame
    wait_frame_start("rst_mid");
    #3 rstn = 1'b0;
    #1;
    check("rst_mid_tx", tx_w, 1);
    check("rst_mid_led", led, 3'b000);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    wait_frame_start("after_rst");
    check_frame(8'hBF, "after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
